// File: rtl/beat_blink_coder.sv
// beat_blink_coder
//   Consumes the board heartbeat square wave and drives a status LED with a
//   repeating blink code: `code` flashes (one slot on, one slot off each),
//   then GAP_BEATS dark slots. A slot is the time between two rising edges of
//   the synchronised beat. A watchdog flags a dead beat source and shows it as
//   a steady-on LED until the next rising edge restarts the blink code.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   beat         heartbeat square wave (may be asynchronous to clk)
//   code         blinks per frame, sampled at each frame start; 0 = dark frame
//   led          status LED drive, 1 = on
//   frame_start  one-cycle pulse at each frame boundary
//   beat_lost    high while the watchdog has expired
module beat_blink_coder #(
  parameter int CODE_W         = 4,
  parameter int GAP_BEATS      = 4,
  parameter int TIMEOUT_CYCLES = 15000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              beat,
  input  logic [CODE_W-1:0] code,
  output logic              led,
  output logic              frame_start,
  output logic              beat_lost
);

  localparam int               GAP_W    = (GAP_BEATS > 1) ? $clog2(GAP_BEATS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BEATS - 1);
  localparam logic [31:0]      WD_LAST  = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  // Watchdog count that sticks at its terminal value instead of wrapping.
  function automatic logic [31:0] wd_sat_inc(input logic [31:0] v);
    return (v == WD_LAST) ? v : v + 32'd1;
  endfunction

  // Stage p0/p1: two-flop synchroniser; stage p2: previous synced level.
  logic beat_s1_p0, beat_s2_p1, beat_s3_p2;
  logic tick, any_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_s1_p0 <= 1'b0;
      beat_s2_p1 <= 1'b0;
      beat_s3_p2 <= 1'b0;
    end else begin
      beat_s1_p0 <= beat;
      beat_s2_p1 <= beat_s1_p0;
      beat_s3_p2 <= beat_s2_p1;
    end
  end

  assign tick     = beat_s2_p1 & ~beat_s3_p2;
  assign any_edge = beat_s2_p1 ^ beat_s3_p2;

  // Watchdog: any synced edge restarts the count; an edge in the expiry
  // cycle suppresses expiry.
  logic [31:0] wd_cnt;
  logic        expire;

  assign expire = (wd_cnt == WD_LAST) && !any_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (any_edge) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_sat_inc(wd_cnt);
    end
  end

  // Blink-code FSM
  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   blink_cnt, blink_d;
  logic [GAP_W-1:0]    gap_cnt, gap_d;
  logic                start;
  logic                lost_d;
  logic                led_d;
  logic                fs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      code_q      <= '0;
      blink_cnt   <= '0;
      gap_cnt     <= '0;
      led         <= 1'b0;
      frame_start <= 1'b0;
      beat_lost   <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      blink_cnt   <= blink_d;
      gap_cnt     <= gap_d;
      led         <= led_d;
      frame_start <= fs_d;
      beat_lost   <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    blink_d = blink_cnt;
    gap_d   = gap_cnt;
    start   = 1'b0;

    if (expire) begin
      state_d = S_IDLE;
    end else if (tick) begin
      unique case (state_q)
        S_IDLE: start = 1'b1;
        S_ON: begin
          state_d = S_OFF;
          blink_d = blink_cnt + CODE_W'(1);
        end
        S_OFF: begin
          if (blink_cnt == code_q) begin
            state_d = S_GAP;
            gap_d   = '0;
          end else begin
            state_d = S_ON;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) start = 1'b1;
          else                     gap_d = gap_cnt + GAP_W'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Frame start: latch the new code and restart both counters.
    if (start) begin
      code_d  = code;
      blink_d = '0;
      gap_d   = '0;
      state_d = (code != '0) ? S_ON : S_GAP;
    end
  end

  // Recovery needs no special case: the FSM sits in IDLE while lost, so the
  // first tick both clears beat_lost and starts a frame.
  always_comb begin
    lost_d = beat_lost;
    if (expire)    lost_d = 1'b1;
    else if (tick) lost_d = 1'b0;
    led_d = lost_d | (state_d == S_ON);
    fs_d  = start;
  end

endmodule

// File: tb/tb_beat_blink_coder.sv
// tb_beat_blink_coder
//   Directed bench for beat_blink_coder with CODE_W=4, GAP_BEATS=2,
//   TIMEOUT_CYCLES=40. The beat is driven 1 time unit after a rising clk edge
//   and toggles every 8 clk, so one slot is 16 clk and the LED for a slot is
//   valid 3 clk after the beat rises.
module tb_beat_blink_coder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       beat;
  logic [3:0] code;
  logic       led;
  logic       frame_start;
  logic       beat_lost;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fs_last = 0;
  int fs_period = 0;

  beat_blink_coder #(
    .CODE_W(4),
    .GAP_BEATS(2),
    .TIMEOUT_CYCLES(40)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .beat(beat),
    .code(code),
    .led(led),
    .frame_start(frame_start),
    .beat_lost(beat_lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Distance in clk cycles between consecutive frame_start samples.
  always @(negedge clk) begin
    if (frame_start) begin
      fs_period = cyc - fs_last;
      fs_last   = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected LED for slot position pos of a frame with c blinks, 2 gap slots.
  function automatic logic exp_led(input int c, input int pos);
    return (pos < 2 * c) && (pos % 2 == 0);
  endfunction

  // One slot; entered 1 unit after a rising clk edge, returns 16 clk later.
  task automatic run_slot(input logic [3:0] code_mid,
                          output logic led_pre, output logic lost_pre,
                          output logic led_v, output logic fs_v, output logic lost_v);
    beat = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    led_pre  = led;
    lost_pre = beat_lost;
    @(posedge clk);
    @(negedge clk);
    led_v  = led;
    fs_v   = frame_start;
    lost_v = beat_lost;
    code   = code_mid;
    repeat (5) @(posedge clk);
    #1 beat = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int c, input int first, input int n,
                           input int chg_i, input logic [3:0] chg_code, input string tag);
    logic lp, lsp, lv, fv, lsv;
    int   pos;
    for (int i = 0; i < n; i++) begin
      pos = (first + i) % (2 * c + 2);
      run_slot((i == chg_i) ? chg_code : code, lp, lsp, lv, fv, lsv);
      check_val($sformatf("%s led slot %0d", tag, first + i), 32'(lv), 32'(exp_led(c, pos)));
      check_val($sformatf("%s fs slot %0d", tag, first + i), 32'(fv), 32'(pos == 0));
    end
  endtask

  initial begin
    logic       lp, lsp, lv, fv, lsv;
    logic [7:0] pat3;
    pat3 = 8'b0001_0101;  // bit i = LED in slot i of a code=3 frame

    rst_n = 1'b0;
    beat  = 1'b0;
    code  = 4'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset led", 32'(led), 32'd0);
    check_val("reset fs", 32'(frame_start), 32'd0);
    check_val("reset lost", 32'(beat_lost), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // code=3: 1,0,1,0,1,0,0,0 every 8 slots
    for (int i = 0; i < 16; i++) begin
      run_slot(4'd3, lp, lsp, lv, fv, lsv);
      check_val($sformatf("c3 pre slot %0d", i), 32'(lp), (i == 0) ? 32'd0 : 32'(pat3[(i - 1) % 8]));
      check_val($sformatf("c3 led slot %0d", i), 32'(lv), 32'(pat3[i % 8]));
      check_val($sformatf("c3 fs slot %0d", i), 32'(fv), 32'((i % 8) == 0));
    end
    check_val("c3 lost", 32'(lsv), 32'd0);
    check_val("c3 fs period", 32'(fs_period), 32'd128);

    // Asynchronous reset in the middle of an ON slot
    beat = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("pre-rst led", 32'(led), 32'd1);
    check_val("pre-rst fs", 32'(frame_start), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async rst led", 32'(led), 32'd0);
    check_val("async rst fs", 32'(frame_start), 32'd0);
    check_val("async rst lost", 32'(beat_lost), 32'd0);
    repeat (5) @(posedge clk);
    #1 beat = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    run_slot(4'd0, lp, lsp, lv, fv, lsv);
    check_val("post-rst pre led", 32'(lp), 32'd0);
    check_val("post-rst led", 32'(lv), 32'd1);
    check_val("post-rst fs", 32'(fv), 32'd1);

    // code dropped to 0 mid-frame: current code=3 frame completes first
    run_frame(3, 1, 7, -1, 4'd0, "c3tail");
    run_frame(0, 0, 6, 5, 4'd2, "c0");
    check_val("c0 fs period", 32'(fs_period), 32'd32);

    // code=2, switched to 5 during the first ON slot
    run_frame(2, 0, 6, 0, 4'd5, "c2");
    run_frame(5, 0, 12, 11, 4'd15, "c5");
    check_val("c5 fs period", 32'(fs_period), 32'd96);

    // Maximum code: 32-slot frame, next frame starts normally
    run_frame(15, 0, 33, 32, 4'd0, "c15");
    check_val("c15 fs period", 32'(fs_period), 32'd512);

    // Beat held low: last fall synced 5 clk ago, expiry 40 clk after that
    repeat (34) @(posedge clk);
    @(negedge clk);
    check_val("wd before expiry", 32'(beat_lost), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("wd expiry lost", 32'(beat_lost), 32'd1);
    check_val("wd expiry led", 32'(led), 32'd1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_val("lost steady led", 32'(led), 32'd1);
    check_val("lost steady fs", 32'(frame_start), 32'd0);
    check_val("lost steady lost", 32'(beat_lost), 32'd1);

    // Recovery on the first tick, code=0 so led drops immediately
    @(posedge clk);
    #1;
    run_slot(4'd0, lp, lsp, lv, fv, lsv);
    check_val("recover pre lost", 32'(lsp), 32'd1);
    check_val("recover pre led", 32'(lp), 32'd1);
    check_val("recover lost", 32'(lsv), 32'd0);
    check_val("recover fs", 32'(fv), 32'd1);
    check_val("recover led", 32'(lv), 32'd0);
    run_slot(4'd0, lp, lsp, lv, fv, lsv);
    check_val("recover slot1 fs", 32'(fv), 32'd0);
    check_val("recover slot1 led", 32'(lv), 32'd0);

    // Edge arriving in the expiry cycle: beat changes 40 clk apart
    beat = 1'b1;
    repeat (40) @(posedge clk);
    #1 beat = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("edge vs expiry lost", 32'(beat_lost), 32'd0);
    repeat (39) @(posedge clk);
    @(negedge clk);
    check_val("wd2 before expiry", 32'(beat_lost), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("wd2 expiry lost", 32'(beat_lost), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
